// File: rtl/tiger_data_responder.sv
// Data-memory responder: turns one pipeline load/store into a word-aligned
// Avalon-MM transaction and returns right-justified load data.
module tiger_data_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        mem8,
    input  logic        mem16,
    input  logic [31:0] memaddress,
    input  logic [31:0] memwritedata,
    output logic        memCanRead,
    output logic        memCanWrite,
    output logic [31:0] readdata,
    output logic        readvalid,
    output logic        misaligned,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITE     = 2'd1;
    localparam logic [1:0] READ_CMD  = 2'd2;
    localparam logic [1:0] READ_WAIT = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] avm_address_q, avm_address_d;
    logic [31:0] avm_writedata_q, avm_writedata_d;
    logic [3:0]  avm_byteenable_q, avm_byteenable_d;
    logic        avm_read_q, avm_read_d;
    logic        avm_write_q, avm_write_d;
    logic [31:0] readdata_q, readdata_d;
    logic        readvalid_q, readvalid_d;
    logic        misaligned_q, misaligned_d;

    logic [1:0]  req_size;
    logic [1:0]  req_lane;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        req_misaligned;
    logic [31:0] rd_shifted;
    logic [31:0] rd_lane_data;

    // Lane decode of the incoming request; byte sizing wins if both size bits are set.
    // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        req_lane       = memaddress[1:0];
        req_size       = SZ_WORD;
        req_be         = 4'b1111;
        req_wdata      = memwritedata;
        req_misaligned = (req_lane != 2'b00);
        if (mem8) begin
            req_size       = SZ_BYTE;
            req_be         = 4'b0001 << req_lane;
            req_wdata      = {4{memwritedata[7:0]}};
            req_misaligned = 1'b0;
        end else if (mem16) begin
            req_size       = SZ_HALF;
            req_be         = req_lane[1] ? 4'b1100 : 4'b0011;
            req_wdata      = {2{memwritedata[15:0]}};
            req_misaligned = req_lane[0];
        end
    end

    // Selected read lane, shifted down to bit 0 and zero-filled.
    always_comb begin
        rd_shifted   = avm_readdata >> {lane_q, 3'b000};
        rd_lane_data = avm_readdata;
        case (size_q)
            SZ_BYTE: rd_lane_data = {24'd0, rd_shifted[7:0]};
            SZ_HALF: rd_lane_data = lane_q[1] ? {16'd0, avm_readdata[31:16]}
                                              : {16'd0, avm_readdata[15:0]};
            default: rd_lane_data = avm_readdata;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        size_d           = size_q;
        lane_d           = lane_q;
        avm_address_d    = avm_address_q;
        avm_writedata_d  = avm_writedata_q;
        avm_byteenable_d = avm_byteenable_q;
        avm_read_d       = avm_read_q;
        avm_write_d      = avm_write_q;
        readdata_d       = readdata_q;
        readvalid_d      = 1'b0;
        misaligned_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (memread || memwrite) begin
                    size_d           = req_size;
                    lane_d           = req_lane;
                    avm_address_d    = {memaddress[31:2], 2'b00};
                    avm_writedata_d  = req_wdata;
                    avm_byteenable_d = req_be;
                    misaligned_d     = req_misaligned;
                    // A simultaneous read and write issues only the write.
                    if (memwrite) begin
                        state_d     = WRITE;
                        avm_write_d = 1'b1;
                    end else begin
                        state_d    = READ_CMD;
                        avm_read_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (!avm_waitrequest) begin
                    state_d     = IDLE;
                    avm_write_d = 1'b0;
                end
            end
            READ_CMD: begin
                if (!avm_waitrequest) begin
                    state_d    = READ_WAIT;
                    avm_read_d = 1'b0;
                end
            end
            default: begin
                if (avm_readdatavalid) begin
                    state_d     = IDLE;
                    readdata_d  = rd_lane_data;
                    readvalid_d = 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= IDLE;
            size_q           <= SZ_BYTE;
            lane_q           <= 2'b00;
            avm_address_q    <= 32'd0;
            avm_writedata_q  <= 32'd0;
            avm_byteenable_q <= 4'd0;
            avm_read_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            readdata_q       <= 32'd0;
            readvalid_q      <= 1'b0;
            misaligned_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            size_q           <= size_d;
            lane_q           <= lane_d;
            avm_address_q    <= avm_address_d;
            avm_writedata_q  <= avm_writedata_d;
            avm_byteenable_q <= avm_byteenable_d;
            avm_read_q       <= avm_read_d;
            avm_write_q      <= avm_write_d;
            readdata_q       <= readdata_d;
            readvalid_q      <= readvalid_d;
            misaligned_q     <= misaligned_d;
        end
    end

    assign memCanRead     = (state_q == IDLE);
    assign memCanWrite    = (state_q == IDLE);
    assign readdata       = readdata_q;
    assign readvalid      = readvalid_q;
    assign misaligned     = misaligned_q;
    assign avm_address    = avm_address_q;
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_writedata  = avm_writedata_q;
    assign avm_byteenable = avm_byteenable_q;

endmodule

// File: tb/tb_tiger_data_responder.sv
// Directed bench for tiger_data_responder: table of transactions against a
// cycle-level Avalon slave, plus reset and mid-transaction reset sequences.
module tb_tiger_data_responder;

    logic        clk;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic        mem8;
    logic        mem16;
    logic [31:0] memaddress;
    logic [31:0] memwritedata;
    logic        memCanRead;
    logic        memCanWrite;
    logic [31:0] readdata;
    logic        readvalid;
    logic        misaligned;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;

    int total = 0;
    int bad   = 0;

    tiger_data_responder dut (
        .clk              (clk),
        .reset            (reset),
        .memread          (memread),
        .memwrite         (memwrite),
        .mem8             (mem8),
        .mem16            (mem16),
        .memaddress       (memaddress),
        .memwritedata     (memwritedata),
        .memCanRead       (memCanRead),
        .memCanWrite      (memCanWrite),
        .readdata         (readdata),
        .readvalid        (readvalid),
        .misaligned       (misaligned),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_write        (avm_write),
        .avm_writedata    (avm_writedata),
        .avm_byteenable   (avm_byteenable),
        .avm_readdata     (avm_readdata),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        m8;
        logic        m16;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_n;
        int          rdv_delay;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_be;
        logic [31:0] e_rd;
        int          e_busy;
        int          e_rdcmd;
        int          e_wrcmd;
        int          e_mis;
        int          e_rv;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
    task automatic run_txn(input int idx, input vec_t v);
        int          cmd_n = 0, wait_n = 0, busy = 0, mis_n = 0, rv_n = 0;
        int          rd_cmd = 0, wr_cmd = 0;
        logic [31:0] rd_val = 32'd0, cap_addr = 32'd0, cap_wd = 32'd0;
        logic [3:0]  cap_be = 4'd0;
        logic        done = 1'b0, held = 1'b1;

        check($sformatf("v%0d_can_read", idx),  {31'd0, memCanRead},  32'd1);
        check($sformatf("v%0d_can_write", idx), {31'd0, memCanWrite}, 32'd1);
        memread           = v.rd;
        memwrite          = v.wr;
        mem8              = v.m8;
        mem16             = v.m16;
        memaddress        = v.addr;
        memwritedata      = v.wdata;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'd0;
        @(negedge clk);
        // Requests presented while busy must be ignored.
        memread      = 1'b1;
        memwrite     = 1'b1;
        mem8         = 1'b0;
        mem16        = 1'b0;
        memaddress   = 32'hFFFF_FFFC;
        memwritedata = 32'h0BAD_0BAD;
        for (int c = 0; c < 40 && !done; c++) begin
            if (misaligned) mis_n++;
            if (readvalid) begin
                rv_n++;
                rd_val = readdata;
            end
            if (memCanRead) begin
                done = 1'b1;
            end else begin
                busy++;
                avm_waitrequest   = 1'b0;
                avm_readdatavalid = 1'b0;
                if (avm_read || avm_write) begin
                    cmd_n++;
                    if (avm_read) rd_cmd++;
                    else wr_cmd++;
                    if (cmd_n == 1) begin
                        cap_addr = avm_address;
                        cap_be   = avm_byteenable;
                        cap_wd   = avm_writedata;
                    end else if (avm_address !== cap_addr || avm_byteenable !== cap_be ||
                                 avm_writedata !== cap_wd) begin
                        held = 1'b0;
                    end
                    avm_waitrequest = (cmd_n <= v.wait_n);
                    if (avm_write) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = 32'hBAD0_BAD0;
                    end
                end else begin
                    wait_n++;
                    avm_readdatavalid = (wait_n > v.rdv_delay);
                    avm_readdata      = v.rdata;
                end
                @(negedge clk);
            end
        end
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        check($sformatf("v%0d_completed", idx),  {31'd0, done}, 32'd1);
        check($sformatf("v%0d_busy", idx),       busy,   v.e_busy);
        check($sformatf("v%0d_read_cmd", idx),   rd_cmd, v.e_rdcmd);
        check($sformatf("v%0d_write_cmd", idx),  wr_cmd, v.e_wrcmd);
        check($sformatf("v%0d_cmd_held", idx),   {31'd0, held}, 32'd1);
        check($sformatf("v%0d_address", idx),    cap_addr, v.e_addr);
        check($sformatf("v%0d_byteenable", idx), {28'd0, cap_be}, {28'd0, v.e_be});
        check($sformatf("v%0d_writedata", idx),  cap_wd, v.e_wd);
        check($sformatf("v%0d_misaligned", idx), mis_n, v.e_mis);
        check($sformatf("v%0d_readvalid", idx),  rv_n,  v.e_rv);
        if (v.rd && !v.wr) check($sformatf("v%0d_readdata", idx), rd_val, v.e_rd);
    endtask

    vec_t vecs[12];

    initial begin
        //           rd    wr    m8    m16   addr          wdata         rdata        wt dl  e_addr        e_wd          be       e_rd         bsy rc wc ms rv
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,       0, 0, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 32'h0,        1, 0, 1, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0,       0, 0, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000, 32'h0,        1, 0, 1, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1003, 32'h0,         32'h1122_3344, 0, 0, 32'h0000_1000, 32'h0,       4'b1000, 32'h0000_0011, 2, 1, 0, 0, 1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2002, 32'h0,         32'hCAFE_BABE, 3, 1, 32'h0000_2000, 32'h0,       4'b1100, 32'h0000_CAFE, 6, 4, 0, 0, 1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3001, 32'h0,         32'h1234_5678, 0, 0, 32'h0000_3000, 32'h0,       4'b1111, 32'h1234_5678, 2, 1, 0, 1, 1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_4000, 32'h0000_55AA, 32'h0,       0, 0, 32'h0000_4000, 32'h0000_55AA, 4'b1111, 32'h0,        1, 0, 1, 0, 0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2001, 32'hBEEF_1234, 32'h0,       0, 0, 32'h0000_2000, 32'h1234_1234, 4'b0011, 32'h0,        1, 0, 1, 1, 0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1001, 32'h0,         32'h1122_3344, 0, 0, 32'h0000_1000, 32'h0,       4'b0010, 32'h0000_0033, 2, 1, 0, 0, 1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0,         32'hCAFE_BABE, 0, 2, 32'h0000_0000, 32'h0,       4'b0011, 32'h0000_BABE, 4, 1, 0, 0, 1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0102_0304, 32'h0,       2, 0, 32'h0000_0008, 32'h0102_0304, 4'b1111, 32'h0,        3, 0, 3, 0, 0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 32'h0000_00C3, 32'h1122_3344, 0, 0, 32'h0000_0000, 32'hC3C3_C3C3, 4'b0100, 32'h0000_0022, 2, 1, 0, 0, 1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1006, 32'hAABB_CCDD, 32'h0,       0, 0, 32'h0000_1004, 32'hAABB_CCDD, 4'b1111, 32'h0,        1, 0, 1, 1, 0};

        reset             = 1'b0;
        memread           = 1'b0;
        memwrite          = 1'b0;
        mem8              = 1'b0;
        mem16             = 1'b0;
        memaddress        = 32'd0;
        memwritedata      = 32'd0;
        avm_readdata      = 32'd0;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_can_read",   {31'd0, memCanRead},  32'd1);
        check("rst_can_write",  {31'd0, memCanWrite}, 32'd1);
        check("rst_avm_read",   {31'd0, avm_read},    32'd0);
        check("rst_avm_write",  {31'd0, avm_write},   32'd0);
        check("rst_readvalid",  {31'd0, readvalid},   32'd0);
        check("rst_misaligned", {31'd0, misaligned},  32'd0);
        check("rst_readdata",   readdata,             32'd0);
        check("rst_address",    avm_address,          32'd0);
        check("rst_byteenable", {28'd0, avm_byteenable}, 32'd0);
        check("rst_writedata",  avm_writedata,        32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back: each new request is presented in the readvalid cycle of the previous one.
        for (int i = 0; i < 12; i++) run_txn(i, vecs[i]);
        memread  = 1'b0;
        memwrite = 1'b0;
        @(negedge clk);

        // Reset while in READ_WAIT abandons the read; later readdatavalid is ignored.
        memread    = 1'b1;
        mem8       = 1'b0;
        mem16      = 1'b0;
        memaddress = 32'h0000_5000;
        @(negedge clk);
        memread = 1'b0;
        check("mid_read_cmd", {31'd0, avm_read}, 32'd1);
        @(negedge clk);
        check("mid_in_wait_rd",   {31'd0, avm_read},   32'd0);
        check("mid_in_wait_busy", {31'd0, memCanRead}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        reset             = 1'b1;
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hFFFF_FFFF;
        check("mid_rst_readdata", readdata, 32'd0);
        check("mid_rst_address",  avm_address, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("mid_after_%0d_readvalid", c), {31'd0, readvalid},   32'd0);
            check($sformatf("mid_after_%0d_can_read", c),  {31'd0, memCanRead},  32'd1);
            check($sformatf("mid_after_%0d_can_write", c), {31'd0, memCanWrite}, 32'd1);
            check($sformatf("mid_after_%0d_avm_read", c),  {31'd0, avm_read},    32'd0);
        end
        avm_readdatavalid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tiger_data_responder.md
# tiger_data_responder

Memory-side responder for the Tiger execute stage's data-memory request interface. It accepts one load or store per handshake from the pipeline (`memread`/`memwrite` with `mem8`/`mem16` sizing) and converts it into a word-aligned Avalon-MM master transaction with byte enables. It returns right-justified read data to the memory-access stage. It deasserts `memCanRead`/`memCanWrite` while a transaction is outstanding, which stalls the pipeline.

## Interface
- No parameters; address and data are fixed at 32 bits.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low: `reset==0` at a `clk` edge resets the block.
- `memread`  in  1  load request from the execute stage.
- `memwrite`  in  1  store request from the execute stage.
- `mem8`  in  1  byte access.
- `mem16`  in  1  halfword access; word access when `mem8` and `mem16` are both 0.
- `memaddress`  in  32  byte address.
- `memwritedata`  in  32  store data, right-justified.
- `memCanRead`  out  1  block can accept a load this cycle.
- `memCanWrite`  out  1  block can accept a store this cycle.
- `readdata`  out  32  load result, right-justified, upper bits zero.
- `readvalid`  out  1  one-cycle pulse; `readdata` is valid.
- `misaligned`  out  1  one-cycle pulse: the accepted request was misaligned.
- `avm_address`  out  32  word address (bits [1:0] = 0).
- `avm_read`  out  1  Avalon read command.
- `avm_write`  out  1  Avalon write command.
- `avm_writedata`  out  32  lane-replicated store data.
- `avm_byteenable`  out  4  active byte lanes.
- `avm_readdata`  in  32  Avalon read data.
- `avm_waitrequest`  in  1  Avalon slave not ready.
- `avm_readdatavalid`  in  1  Avalon read data valid.

## Operation
- FSM states: IDLE, WRITE, READ_CMD, READ_WAIT.
- `memCanRead = memCanWrite = (state==IDLE)`.
- All other outputs are registered.

Request acceptance (IDLE only):
- A request is accepted on a `clk` edge in IDLE with `memread|memwrite`.
- The block captures address, size, and data on that edge.
- If both `memread` and `memwrite` are set, the write wins and the read is dropped.
- Requests presented outside IDLE are ignored.

Lane mapping (little-endian), taken from `a = memaddress[1:0]`:
- Byte: `avm_byteenable = 4'b0001<<a`; `avm_writedata = {4{d[7:0]}}`.
- Half: `avm_byteenable = a[1] ? 4'b1100 : 4'b0011`; `avm_writedata = {2{d[15:0]}}`.
- Word: `avm_byteenable = 4'b1111`; `avm_writedata = d`.
- `avm_address = {memaddress[31:2], 2'b00}`.

Misalignment:
- A half access with `a[0]==1`, or a word access with `a!=0`, pulses `misaligned` for the cycle after acceptance.
- The access still proceeds using the aligned lanes given above.

State transitions:
- WRITE: `avm_write=1`. Holds command outputs while `avm_waitrequest=1`. On an edge with `avm_waitrequest=0`, goes to IDLE.
- READ_CMD: `avm_read=1`. Holds while waitrequest is high. On an edge with waitrequest low, goes to READ_WAIT.
- READ_WAIT: `avm_read=0`. On an edge with `avm_readdatavalid=1`:
  - the selected lane, shifted down to bit 0 and zero-filled, is registered into `readdata`;
  - `readvalid` pulses;
  - state goes to IDLE.
- `readdatavalid` in any state other than READ_WAIT is ignored.
- `readdata` holds its value until the next completed read.

## Timing
Reset (`reset==0`) values:
- state = IDLE, so `memCanRead=memCanWrite=1`.
- `avm_read=avm_write=0`.
- `readvalid=misaligned=0`.
- `readdata=0`, `avm_address=0`, `avm_byteenable=0`, `avm_writedata=0`.

Reset mid-transaction:
- Reset abandons the transaction with no `readvalid`.
- Any readdatavalid that arrives later is ignored.

Store latency (accept on edge E):
- `avm_write` is high from E+1.
- With zero waitrequest, IDLE is reached at E+2, so `memCanWrite` is low for exactly 1 cycle.

Load latency (accept on edge E):
- `avm_read` is high from E+1 and is accepted at E+2.
- If readdatavalid arrives in the first READ_WAIT cycle, `readvalid` is high and the state is IDLE after E+3.
- Minimum busy window is 2 cycles.
- Each cycle of waitrequest or readdatavalid delay adds one cycle.

Outstanding requests: at most one at any time. A new request can be accepted in the same cycle that `readvalid` is high.

## Test plan
- Word store, address 0x1000, data 0xDEADBEEF, waitrequest=0 -> one `avm_write` cycle with address 0x1000, BE 4'b1111, `memCanWrite` low 1 cycle.
- Byte store, address 0x1003, data 0x000000A5 -> BE 4'b1000, writedata 0xA5A5A5A5; byte load from 0x1003 of word 0x11223344 -> `readdata` 0x00000011.
- Half load, address 0x2002, slave word 0xCAFEBABE, waitrequest=1 for 3 cycles, readdatavalid 2 cycles after acceptance -> `avm_read` high 4 cycles, `readdata` 0x0000CAFE, `readvalid` exactly one pulse.
- Word load at 0x3001 -> `misaligned` one pulse, `avm_address` 0x3000, BE 4'b1111.
- `memread` and `memwrite` asserted together -> write issued, no read, no `readvalid`.
- `reset=0` in READ_WAIT, then readdatavalid=1 after release -> state IDLE, `readvalid` stays 0, can-signals 1.
